// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S playback serializer for the WM8731 DAC path.
// Buffers one DATA_W-bit sample from the player and shifts it MSB-first onto
// AUD_DACDAT in the left slot framed by AUD_DACLRCK. All flops update on the
// falling bit-clock edge, so the codec samples data on the rising edge.
// Optional feature macro: I2S_DAC_STEREO_DUP_EN
//   defined   -> the left sample is repeated in the right slot (mono to both ears)
//   undefined -> the right slot is silent and the SEND_R state is not built

module i2s_dac_tx #(
    parameter int DATA_W           = 16,
    parameter bit ZERO_ON_UNDERRUN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              AUD_DACLRCK,
    output logic              AUD_DACDAT,
    output logic              request_play_data,
    input  logic [DATA_W-1:0] play_data,
    input  logic              play_valid,
    output logic              underrun
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAITH  = 3'd1,
        WAITL  = 3'd2,
`ifdef I2S_DAC_STEREO_DUP_EN
        SEND_R = 3'd4,
`endif
        SEND_L = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d;
    logic [CNT_W-1:0]    counter_q, counter_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic                dacdat_q, dacdat_d;
    logic                req_q, req_d;
    logic                underrun_q, underrun_d;
`ifdef I2S_DAC_STEREO_DUP_EN
    // Set when a left word has just been sent, so the next right slot replays it
    logic                dup_q, dup_d;
`endif

    logic [DATA_W-1:0]   underrun_value;
    logic [DATA_W-1:0]   load_value;

    // Word placed in the shifter at the start of a left slot
    always_comb begin
        underrun_value = ZERO_ON_UNDERRUN ? '0 : last_q;
        load_value     = hold_valid_q ? hold_q : underrun_value;
    end

    // Next-state, datapath and output logic; a dropped start overrides everything
    always_comb begin
        state_d      = state_q;
        start_d      = start;
        counter_d    = counter_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        last_d       = last_q;
        dacdat_d     = 1'b0;
        req_d        = 1'b0;
        underrun_d   = 1'b0;
`ifdef I2S_DAC_STEREO_DUP_EN
        dup_d        = dup_q;
`endif

        // Holding register: newest sample wins; a load in the same cycle has
        // already picked up the old value through load_value.
        if (play_valid && (state_q != IDLE)) begin
            hold_d       = play_data;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                hold_valid_d = 1'b0;
`ifdef I2S_DAC_STEREO_DUP_EN
                dup_d        = 1'b0;
`endif
                // Always begin at a full left slot: wait for an LRCK fall
                // that we have seen from the high side.
                if (start_q) begin
                    state_d = AUD_DACLRCK ? WAITL : WAITH;
                end
            end

            WAITH: begin
                if (AUD_DACLRCK) begin
                    state_d = WAITL;
`ifdef I2S_DAC_STEREO_DUP_EN
                    if (dup_q) begin
                        state_d   = SEND_R;
                        shift_d   = last_q;
                        counter_d = '0;
                    end
                    dup_d = 1'b0;
`endif
                end
            end

            WAITL: begin
                if (!AUD_DACLRCK) begin
                    state_d    = SEND_L;
                    shift_d    = load_value;
                    last_d     = load_value;
                    counter_d  = '0;
                    req_d      = 1'b1;
                    underrun_d = ~hold_valid_q;
                    // A sample arriving in the load cycle stays buffered
                    hold_valid_d = play_valid;
                end
            end

            SEND_L: begin
                dacdat_d  = shift_q[DATA_W-1];
                shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                counter_d = counter_q + 1'b1;
                // Word length is counter-bounded, so an early LRCK edge
                // cannot truncate the word or leak a slip into the next frame.
                if (counter_q == LAST_BIT) begin
                    state_d   = WAITH;
                    counter_d = '0;
`ifdef I2S_DAC_STEREO_DUP_EN
                    dup_d     = 1'b1;
`endif
                end
            end

`ifdef I2S_DAC_STEREO_DUP_EN
            SEND_R: begin
                dacdat_d  = shift_q[DATA_W-1];
                shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                counter_d = counter_q + 1'b1;
                if (counter_q == LAST_BIT) begin
                    state_d   = WAITL;
                    counter_d = '0;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        // Playback disabled: abandon the frame at once and drop any buffered sample
        if (!start_q && (state_q != IDLE)) begin
            state_d      = IDLE;
            dacdat_d     = 1'b0;
            req_d        = 1'b0;
            underrun_d   = 1'b0;
            hold_valid_d = 1'b0;
`ifdef I2S_DAC_STEREO_DUP_EN
            dup_d        = 1'b0;
`endif
        end
    end

    // State and datapath registers on the falling bit-clock edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            counter_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            last_q       <= '0;
            dacdat_q     <= 1'b0;
            req_q        <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef I2S_DAC_STEREO_DUP_EN
            dup_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            counter_q    <= counter_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            last_q       <= last_d;
            dacdat_q     <= dacdat_d;
            req_q        <= req_d;
            underrun_q   <= underrun_d;
`ifdef I2S_DAC_STEREO_DUP_EN
            dup_q        <= dup_d;
`endif
        end
    end

    // All outputs come straight from flops
    assign AUD_DACDAT        = dacdat_q;
    assign request_play_data = req_q;
    assign underrun          = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed bench for i2s_dac_tx. Two instances share the
// stimulus: index 0 sends zeros on underrun, index 1 resends the last sample.
// Frames are 64 BCLK long (32 per slot); inputs change on the rising edge,
// outputs are sampled on the rising edge, the DUT updates on the falling edge.
`timescale 1ns/1ps

module tb_i2s_dac_tx;

`ifdef I2S_DAC_STEREO_DUP_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        lrck;
    logic        play_valid;
    logic [15:0] play_data;
    wire  [1:0]  dat_w;
    wire  [1:0]  req_w;
    wire  [1:0]  und_w;

    int total = 0;
    int bad   = 0;

    logic [15:0] cap_l   [2];
    logic [15:0] cap_r   [2];
    int          n_req   [2];
    int          n_und   [2];
    int          n_stray [2];

    always #5 clk = ~clk;

    i2s_dac_tx #(.DATA_W(16), .ZERO_ON_UNDERRUN(1'b1)) dut_zero (
        .clk(clk), .rst(rst), .start(start), .AUD_DACLRCK(lrck),
        .AUD_DACDAT(dat_w[0]), .request_play_data(req_w[0]),
        .play_data(play_data), .play_valid(play_valid), .underrun(und_w[0])
    );

    i2s_dac_tx #(.DATA_W(16), .ZERO_ON_UNDERRUN(1'b0)) dut_last (
        .clk(clk), .rst(rst), .start(start), .AUD_DACLRCK(lrck),
        .AUD_DACDAT(dat_w[1]), .request_play_data(req_w[1]),
        .play_data(play_data), .play_valid(play_valid), .underrun(und_w[1])
    );

    function automatic logic [15:0] exp_right(input logic [15:0] v);
        return DUP ? v : 16'h0000;
    endfunction

    // One 64-BCLK frame starting with the LRCK fall; optional play_valid
    // pulses at frame cycles k1/k2 (0 = coincident with the load, -1 = none).
    task automatic run_frame(input int k1, input logic [15:0] d1,
                             input int k2, input logic [15:0] d2);
        for (int d = 0; d < 2; d++) begin
            cap_l[d] = '0; cap_r[d] = '0;
            n_req[d] = 0;  n_und[d] = 0; n_stray[d] = 0;
        end
        lrck = 1'b0;
        play_valid = 1'b0;
        if (k1 == 0) begin play_data = d1; play_valid = 1'b1; end
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            play_valid = 1'b0;
            if (k == k1) begin play_data = d1; play_valid = 1'b1; end
            if (k == k2) begin play_data = d2; play_valid = 1'b1; end
            if (k == 32) lrck = 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (k >= 2 && k <= 17)       cap_l[d] = {cap_l[d][14:0], dat_w[d]};
                else if (k >= 34 && k <= 49) cap_r[d] = {cap_r[d][14:0], dat_w[d]};
                else if (dat_w[d] !== 1'b0)  n_stray[d]++;
                if (req_w[d] === 1'b1) n_req[d]++;
                if (und_w[d] === 1'b1) n_und[d]++;
            end
        end
        play_valid = 1'b0;
        $display("frame: L=%h/%h R=%h/%h req=%0d/%0d und=%0d/%0d stray=%0d/%0d",
                 cap_l[0], cap_l[1], cap_r[0], cap_r[1], n_req[0], n_req[1],
                 n_und[0], n_und[1], n_stray[0], n_stray[1]);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++; if (dat_w !== 2'b00) begin bad++; $display("FAIL reset_dacdat: got %b want 00", dat_w); end
        total++; if (req_w !== 2'b00) begin bad++; $display("FAIL reset_req: got %b want 00", req_w); end
        total++; if (und_w !== 2'b00) begin bad++; $display("FAIL reset_underrun: got %b want 00", und_w); end
        @(posedge clk);
        rst = 1'b0;
        $display("reset: outputs %b %b %b", dat_w, req_w, und_w);
    endtask

    // IDLE ignores play_valid; the first frame after start therefore underruns
    task automatic test_idle_then_underrun;
        int act;
        act = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            play_valid = (k == 20);
            play_data  = 16'hFFFF;
            if (k == 10) lrck = 1'b0;
            if (k == 40) lrck = 1'b1;
            if ((dat_w | req_w | und_w) !== 2'b00) act++;
        end
        play_valid = 1'b0;
        total++; if (act !== 0) begin bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", act); end
        start = 1'b1;
        repeat (4) @(posedge clk);
        run_frame(40, 16'hA5C3, -1, 16'h0);
        for (int d = 0; d < 2; d++) begin
            total++; if (cap_l[d] !== 16'h0000) begin bad++; $display("FAIL underrun_left dut%0d: got %h want 0000", d, cap_l[d]); end
            total++; if (cap_r[d] !== 16'h0000) begin bad++; $display("FAIL underrun_right dut%0d: got %h want 0000", d, cap_r[d]); end
            total++; if (n_und[d] !== 1) begin bad++; $display("FAIL underrun_pulse dut%0d: got %0d want 1", d, n_und[d]); end
            total++; if (n_req[d] !== 1) begin bad++; $display("FAIL underrun_req dut%0d: got %0d want 1", d, n_req[d]); end
            total++; if (n_stray[d] !== 0) begin bad++; $display("FAIL underrun_stray dut%0d: got %0d want 0", d, n_stray[d]); end
        end
    endtask

    task automatic test_basic;
        run_frame(50, 16'h8001, -1, 16'h0);
        for (int d = 0; d < 2; d++) begin
            total++; if (cap_l[d] !== 16'hA5C3) begin bad++; $display("FAIL basic_left dut%0d: got %h want a5c3", d, cap_l[d]); end
            total++; if (cap_r[d] !== exp_right(16'hA5C3)) begin bad++; $display("FAIL basic_right dut%0d: got %h want %h", d, cap_r[d], exp_right(16'hA5C3)); end
            total++; if (n_req[d] !== 1) begin bad++; $display("FAIL basic_req dut%0d: got %0d want 1", d, n_req[d]); end
            total++; if (n_und[d] !== 0) begin bad++; $display("FAIL basic_underrun dut%0d: got %0d want 0", d, n_und[d]); end
            total++; if (n_stray[d] !== 0) begin bad++; $display("FAIL basic_stray dut%0d: got %0d want 0", d, n_stray[d]); end
        end
    endtask

    // 8001 is sent, then an empty frame: zero on instance 0, resend on instance 1
    task automatic test_resend;
        logic [15:0] exp_l [2];
        run_frame(-1, 16'h0, -1, 16'h0);
        for (int d = 0; d < 2; d++) begin
            total++; if (cap_l[d] !== 16'h8001) begin bad++; $display("FAIL resend_first dut%0d: got %h want 8001", d, cap_l[d]); end
        end
        run_frame(10, 16'h1111, 20, 16'h2222);
        exp_l[0] = 16'h0000;
        exp_l[1] = 16'h8001;
        for (int d = 0; d < 2; d++) begin
            total++; if (cap_l[d] !== exp_l[d]) begin bad++; $display("FAIL resend_left dut%0d: got %h want %h", d, cap_l[d], exp_l[d]); end
            total++; if (cap_r[d] !== exp_right(exp_l[d])) begin bad++; $display("FAIL resend_right dut%0d: got %h want %h", d, cap_r[d], exp_right(exp_l[d])); end
            total++; if (n_und[d] !== 1) begin bad++; $display("FAIL resend_underrun dut%0d: got %0d want 1", d, n_und[d]); end
            total++; if (n_req[d] !== 1) begin bad++; $display("FAIL resend_req dut%0d: got %0d want 1", d, n_req[d]); end
        end
    endtask

    // 2222 overwrote 1111; 3333 arriving with the load is kept for the next frame
    task automatic test_newest_wins;
        run_frame(0, 16'h3333, -1, 16'h0);
        for (int d = 0; d < 2; d++) begin
            total++; if (cap_l[d] !== 16'h2222) begin bad++; $display("FAIL newest_left dut%0d: got %h want 2222", d, cap_l[d]); end
            total++; if (n_und[d] !== 0) begin bad++; $display("FAIL newest_underrun dut%0d: got %0d want 0", d, n_und[d]); end
        end
        run_frame(30, 16'h7FFF, -1, 16'h0);
        for (int d = 0; d < 2; d++) begin
            total++; if (cap_l[d] !== 16'h3333) begin bad++; $display("FAIL coincident_left dut%0d: got %h want 3333", d, cap_l[d]); end
            total++; if (n_und[d] !== 0) begin bad++; $display("FAIL coincident_underrun dut%0d: got %0d want 0", d, n_und[d]); end
        end
    endtask

    task automatic test_stereo;
        run_frame(40, 16'hFFFF, -1, 16'h0);
        for (int d = 0; d < 2; d++) begin
            total++; if (cap_l[d] !== 16'h7FFF) begin bad++; $display("FAIL stereo_left dut%0d: got %h want 7fff", d, cap_l[d]); end
            total++; if (cap_r[d] !== exp_right(16'h7FFF)) begin bad++; $display("FAIL stereo_right dut%0d: got %h want %h", d, cap_r[d], exp_right(16'h7FFF)); end
            total++; if (n_stray[d] !== 0) begin bad++; $display("FAIL stereo_stray dut%0d: got %0d want 0", d, n_stray[d]); end
        end
    endtask

    // start drops at bit 7 of an FFFF word; restart mid-left waits a full frame
    task automatic test_stop_restart;
        logic [7:0] first [2];
        int late_dat [2];
        int late_req [2];
        int late_und [2];
        int act;
        for (int d = 0; d < 2; d++) begin
            first[d] = '0; late_dat[d] = 0; late_req[d] = 0; late_und[d] = 0;
        end
        lrck = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            if (k == 9)  start = 1'b0;
            if (k == 32) lrck = 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (k >= 2 && k <= 9) first[d] = {first[d][6:0], dat_w[d]};
                if (k >= 11 && dat_w[d] !== 1'b0) late_dat[d]++;
                if (k >= 2 && req_w[d] !== 1'b0)  late_req[d]++;
                if (und_w[d] !== 1'b0)            late_und[d]++;
            end
        end
        $display("stop: first=%h/%h late_dat=%0d/%0d late_req=%0d/%0d",
                 first[0], first[1], late_dat[0], late_dat[1], late_req[0], late_req[1]);
        for (int d = 0; d < 2; d++) begin
            total++; if (first[d] !== 8'hFF) begin bad++; $display("FAIL stop_bits dut%0d: got %h want ff", d, first[d]); end
            total++; if (late_dat[d] !== 0) begin bad++; $display("FAIL stop_dacdat dut%0d: got %0d want 0", d, late_dat[d]); end
            total++; if (late_req[d] !== 0) begin bad++; $display("FAIL stop_req dut%0d: got %0d want 0", d, late_req[d]); end
            total++; if (late_und[d] !== 0) begin bad++; $display("FAIL stop_underrun dut%0d: got %0d want 0", d, late_und[d]); end
        end
        act = 0;
        lrck = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            play_valid = (k == 12);
            play_data  = 16'h5A5A;
            if (k == 8)  start = 1'b1;
            if (k == 32) lrck = 1'b1;
            if ((dat_w | req_w | und_w) !== 2'b00) act++;
        end
        play_valid = 1'b0;
        $display("restart: active cycles in partial frame=%0d", act);
        total++; if (act !== 0) begin bad++; $display("FAIL restart_quiet: got %0d active cycles want 0", act); end
        run_frame(-1, 16'h0, -1, 16'h0);
        for (int d = 0; d < 2; d++) begin
            total++; if (cap_l[d] !== 16'h5A5A) begin bad++; $display("FAIL restart_left dut%0d: got %h want 5a5a", d, cap_l[d]); end
            total++; if (cap_r[d] !== exp_right(16'h5A5A)) begin bad++; $display("FAIL restart_right dut%0d: got %h want %h", d, cap_r[d], exp_right(16'h5A5A)); end
            total++; if (n_req[d] !== 1) begin bad++; $display("FAIL restart_req dut%0d: got %0d want 1", d, n_req[d]); end
            total++; if (n_und[d] !== 0) begin bad++; $display("FAIL restart_underrun dut%0d: got %0d want 0", d, n_und[d]); end
        end
    endtask

    // Asynchronous reset in the middle of SEND_L clears outputs immediately
    task automatic test_reset_mid;
        int act;
        lrck = 1'b0;
        @(posedge clk);
        total++; if (req_w !== 2'b11) begin bad++; $display("FAIL mid_pre_req: got %b want 11", req_w); end
        total++; if (und_w !== 2'b11) begin bad++; $display("FAIL mid_pre_underrun: got %b want 11", und_w); end
        #1 rst = 1'b1;
        #1;
        total++; if (req_w !== 2'b00) begin bad++; $display("FAIL mid_rst_req: got %b want 00", req_w); end
        total++; if (und_w !== 2'b00) begin bad++; $display("FAIL mid_rst_underrun: got %b want 00", und_w); end
        $display("reset mid-frame A: req=%b und=%b", req_w, und_w);
        repeat (2) @(posedge clk);
        start = 1'b0;
        rst   = 1'b0;
        lrck  = 1'b1;
        act   = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            play_valid = (k == 5);
            play_data  = 16'hFFFF;
            if (k == 20) lrck = 1'b0;
            if (k == 50) lrck = 1'b1;
            if ((dat_w | req_w | und_w) !== 2'b00) act++;
        end
        play_valid = 1'b0;
        total++; if (act !== 0) begin bad++; $display("FAIL post_reset_idle: got %0d active cycles want 0", act); end
        start = 1'b1;
        repeat (4) @(posedge clk);
        play_data  = 16'hFFFF;
        play_valid = 1'b1;
        @(posedge clk);
        play_valid = 1'b0;
        repeat (3) @(posedge clk);
        lrck = 1'b0;
        repeat (2) @(posedge clk);
        total++; if (dat_w !== 2'b11) begin bad++; $display("FAIL mid_pre_dacdat: got %b want 11", dat_w); end
        #1 rst = 1'b1;
        #1;
        total++; if (dat_w !== 2'b00) begin bad++; $display("FAIL mid_rst_dacdat: got %b want 00", dat_w); end
        $display("reset mid-frame B: dacdat=%b", dat_w);
        repeat (2) @(posedge clk);
        rst  = 1'b0;
        lrck = 1'b1;
        repeat (6) @(posedge clk);
        run_frame(-1, 16'h0, -1, 16'h0);
        for (int d = 0; d < 2; d++) begin
            total++; if (cap_l[d] !== 16'h0000) begin bad++; $display("FAIL post_reset_left dut%0d: got %h want 0000", d, cap_l[d]); end
            total++; if (n_und[d] !== 1) begin bad++; $display("FAIL post_reset_underrun dut%0d: got %0d want 1", d, n_und[d]); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        lrck       = 1'b1;
        play_valid = 1'b0;
        play_data  = 16'h0000;
        test_reset;
        test_idle_then_underrun;
        test_basic;
        test_resend;
        test_newest_wins;
        test_stereo;
        test_stop_restart;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
